// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester, grant and memory-side signal bundle for bus_arbiter
interface bus_arbiter_if;
   logic [3:0]   req;
   logic [3:0]   lock;
   logic [3:0]   rd;
   logic [3:0]   wr;
   logic [127:0] addr_in;
   logic [127:0] wdata_in;
   logic [3:0]   grant;
   logic [1:0]   owner;
   logic         bus_busy;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_rd;
   logic         mem_wr;
   logic [31:0]  mem_rdata;
   logic         mem_ack;
   logic [31:0]  rdata;
   logic [3:0]   rd_dn;
   logic [3:0]   wr_dn;
   logic [3:0]   err;

   // arbiter side
   modport slave (
      input  req, lock, rd, wr, addr_in, wdata_in, mem_rdata, mem_ack,
      output grant, owner, bus_busy, mem_addr, mem_wdata, mem_rd, mem_wr,
             rdata, rd_dn, wr_dn, err
   );

   // requester / memory side
   modport master (
      output req, lock, rd, wr, addr_in, wdata_in, mem_rdata, mem_ack,
      input  grant, owner, bus_busy, mem_addr, mem_wdata, mem_rd, mem_wr,
             rdata, rd_dn, wr_dn, err
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin 4-requester bus arbiter with locked bursts and ack timeout
module bus_arbiter #(
   parameter int NREQ = 4,
   parameter int TMO  = 255
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.slave  bus
);
   localparam logic [7:0] TMO_CNT = 8'(TMO);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t      r_state;
   logic [3:0]  r_grant;
   logic [1:0]  r_owner;
   logic [1:0]  r_last_owner;
   logic        r_busy;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_mem_rd;
   logic        r_mem_wr;
   logic [31:0] r_rdata;
   logic [3:0]  r_rd_dn;
   logic [3:0]  r_wr_dn;
   logic [3:0]  r_err;
   logic [7:0]  r_tmo_cnt;

   logic [1:0]  w_pick;
   logic        w_found;
   logic [3:0]  w_owner_oh;
   logic        w_own_rd;
   logic        w_own_wr;
   logic        w_own_req;
   logic        w_own_lock;
   logic [31:0] w_own_addr;
   logic [31:0] w_own_wdata;
   logic        w_tmo_hit;

   assign w_owner_oh  = 4'b0001 << r_owner;
   assign w_own_rd    = bus.rd[r_owner];
   assign w_own_wr    = bus.wr[r_owner];
   assign w_own_req   = bus.req[r_owner];
   assign w_own_lock  = bus.lock[r_owner];
   assign w_own_addr  = bus.addr_in[{r_owner, 5'd0} +: 32];
   assign w_own_wdata = bus.wdata_in[{r_owner, 5'd0} +: 32];
   // The WAIT cycle whose increment would bring the count to TMO is the timeout cycle.
   assign w_tmo_hit   = (r_tmo_cnt + 8'd1) == TMO_CNT;

   // Round-robin pick: first requester found searching cyclically after the last owner.
   always_comb begin
      w_pick  = 2'd0;
      w_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && bus.req[r_last_owner + 2'(k)]) begin
            w_found = 1'b1;
            w_pick  = r_last_owner + 2'(k);
         end
      end
   end

   // Arbitration / transfer FSM with all outputs registered; pulses default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_grant      <= 4'd0;
         r_owner      <= 2'd0;
         r_last_owner <= 2'd3;
         r_busy       <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_rdata      <= 32'd0;
         r_rd_dn      <= 4'd0;
         r_wr_dn      <= 4'd0;
         r_err        <= 4'd0;
         r_tmo_cnt    <= 8'd0;
      end else begin
         r_rd_dn <= 4'd0;
         r_wr_dn <= 4'd0;
         r_err   <= 4'd0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant <= 4'b0001 << w_pick;
                  r_owner <= w_pick;
                  r_busy  <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (w_own_rd && w_own_wr) begin
                  r_err        <= w_owner_oh;
                  r_grant      <= 4'd0;
                  r_busy       <= 1'b0;
                  r_last_owner <= r_owner;
                  r_state      <= IDLE;
               end else if (w_own_rd || w_own_wr) begin
                  r_mem_addr <= w_own_addr;
                  if (w_own_wr) begin
                     r_mem_wdata <= w_own_wdata;
                  end
                  r_mem_rd  <= w_own_rd;
                  r_mem_wr  <= w_own_wr;
                  r_tmo_cnt <= 8'd0;
                  r_state   <= WAIT;
               end else if (!w_own_req && !w_own_lock) begin
                  r_grant      <= 4'd0;
                  r_busy       <= 1'b0;
                  r_last_owner <= r_owner;
                  r_state      <= IDLE;
               end
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  if (r_mem_rd) begin
                     r_rdata <= bus.mem_rdata;
                     r_rd_dn <= w_owner_oh;
                  end else begin
                     r_wr_dn <= w_owner_oh;
                  end
                  if (w_own_lock) begin
                     r_state <= ISSUE;
                  end else begin
                     r_grant      <= 4'd0;
                     r_busy       <= 1'b0;
                     r_last_owner <= r_owner;
                     r_state      <= IDLE;
                  end
               end else if (w_tmo_hit) begin
                  r_mem_rd     <= 1'b0;
                  r_mem_wr     <= 1'b0;
                  r_err        <= w_owner_oh;
                  r_grant      <= 4'd0;
                  r_busy       <= 1'b0;
                  r_last_owner <= r_owner;
                  r_state      <= IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.grant     = r_grant;
   assign bus.owner     = r_owner;
   assign bus.bus_busy  = r_busy;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_rd    = r_mem_rd;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.rdata     = r_rdata;
   assign bus.rd_dn     = r_rd_dn;
   assign bus.wr_dn     = r_wr_dn;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_arbiter_if bus ();

   bus_arbiter #(.NREQ(4), .TMO(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_last;
   logic [31:0] m_rdata;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Next owner: first requesting index scanning cyclically after the previous owner.
   function automatic int model_pick(logic [3:0] r, int last);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return 0;
   endfunction

   task automatic clear_inputs();
      bus.req = '0; bus.lock = '0; bus.rd = '0; bus.wr = '0;
      bus.addr_in = '0; bus.wdata_in = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = 4'hF; bus.rd = 4'hF; bus.lock = 4'hF; bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      step(); step();
      n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
      n_checks++; if (bus.owner !== 2'd0) begin n_errors++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
      n_checks++; if (bus.bus_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.bus_busy); end
      n_checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) begin n_errors++; $display("FAIL reset_mem_strobe: got %b want 00", {bus.mem_rd, bus.mem_wr}); end
      n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 96'd0) begin n_errors++; $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.rdata}); end
      n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err} !== 12'd0) begin n_errors++; $display("FAIL reset_pulses: got %h want 000", {bus.rd_dn, bus.wr_dn, bus.err}); end
      rst = 1'b0;
      clear_inputs();
      m_last = 3;
      m_rdata = 32'd0;
      step();
   endtask

   task automatic test_rotation();
      logic [3:0] exp_oh;
      bus.req = 4'b0101;
      exp_oh = 4'b0001 << model_pick(4'b0101, m_last);
      step();
      n_checks++; if (bus.grant !== exp_oh) begin n_errors++; $display("FAIL rot_first_grant: got %b want %b", bus.grant, exp_oh); end
      n_checks++; if (bus.bus_busy !== 1'b1) begin n_errors++; $display("FAIL rot_busy: got %b want 1", bus.bus_busy); end
      bus.wr[0] = 1'b1; bus.addr_in[31:0] = 32'h40; bus.wdata_in[31:0] = 32'h1234_5678;
      step();
      n_checks++; if ({bus.mem_wr, bus.mem_wdata} !== {1'b1, 32'h1234_5678}) begin n_errors++; $display("FAIL rot_write_issue: got %b/%h want 1/12345678", bus.mem_wr, bus.mem_wdata); end
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0; bus.wr[0] = 1'b0;
      m_last = 0;
      n_checks++; if ({bus.wr_dn, bus.grant} !== {4'b0001, 4'b0000}) begin n_errors++; $display("FAIL rot_release: got wr_dn=%b grant=%b want 0001/0000", bus.wr_dn, bus.grant); end
      exp_oh = 4'b0001 << model_pick(4'b0101, m_last);
      step();
      n_checks++; if (bus.grant !== exp_oh) begin n_errors++; $display("FAIL rot_second_grant: got %b want %b", bus.grant, exp_oh); end
      n_checks++; if (bus.owner !== 2'd2) begin n_errors++; $display("FAIL rot_owner: got %0d want 2", bus.owner); end
      bus.req = 4'b0000;
      step();
      m_last = 2;
      n_checks++; if ({bus.grant, bus.bus_busy} !== 5'd0) begin n_errors++; $display("FAIL rot_idle_release: got %b/%b want 0000/0", bus.grant, bus.bus_busy); end
   endtask

   task automatic test_read();
      int hi;
      bus.req = 4'b0010; bus.rd[1] = 1'b1; bus.addr_in[63:32] = 32'h100;
      step();
      n_checks++; if (bus.grant !== 4'b0010) begin n_errors++; $display("FAIL rd_grant: got %b want 0010", bus.grant); end
      step();
      n_checks++; if (bus.mem_addr !== 32'h100) begin n_errors++; $display("FAIL rd_addr: got %h want 00000100", bus.mem_addr); end
      hi = 0;
      for (int c = 1; c <= 3; c++) begin
         if (bus.mem_rd === 1'b1) hi++;
         if (c < 3) step();
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; bus.req = 4'b0000; bus.rd = 4'b0000;
      step();
      bus.mem_ack = 1'b0;
      m_rdata = 32'hDEAD_BEEF; m_last = 1;
      n_checks++; if (hi !== 3) begin n_errors++; $display("FAIL rd_strobe_len: got %0d want 3", hi); end
      n_checks++; if ({bus.rd_dn, bus.mem_rd} !== {4'b0010, 1'b0}) begin n_errors++; $display("FAIL rd_done: got rd_dn=%b mem_rd=%b want 0010/0", bus.rd_dn, bus.mem_rd); end
      n_checks++; if (bus.rdata !== m_rdata) begin n_errors++; $display("FAIL rd_rdata: got %h want %h", bus.rdata, m_rdata); end
      step();
      n_checks++; if (bus.rd_dn !== 4'b0000) begin n_errors++; $display("FAIL rd_pulse_width: got %b want 0000", bus.rd_dn); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
      step(); step();
      bus.mem_ack = 1'b0;
      n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err, bus.grant} !== 16'd0) begin n_errors++; $display("FAIL stray_ack_pulses: got %h want 0000", {bus.rd_dn, bus.wr_dn, bus.err, bus.grant}); end
      n_checks++; if (bus.rdata !== m_rdata) begin n_errors++; $display("FAIL stray_ack_rdata: got %h want %h", bus.rdata, m_rdata); end
   endtask

   task automatic test_lock();
      logic [31:0] rv, wv;
      logic [3:0]  exp_oh;
      rv = $urandom; wv = $urandom;
      bus.req = 4'b0101; bus.lock[2] = 1'b1; bus.rd[2] = 1'b1; bus.addr_in[95:64] = 32'h20;
      exp_oh = 4'b0001 << model_pick(4'b0101, m_last);
      step();
      n_checks++; if (bus.grant !== exp_oh) begin n_errors++; $display("FAIL lock_grant: got %b want %b", bus.grant, exp_oh); end
      step();
      n_checks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 32'h20}) begin n_errors++; $display("FAIL lock_rd_issue: got %b/%h want 1/00000020", bus.mem_rd, bus.mem_addr); end
      bus.mem_ack = 1'b1; bus.mem_rdata = rv; bus.rd[2] = 1'b0; bus.wr[2] = 1'b1; bus.wdata_in[95:64] = wv;
      step();
      bus.mem_ack = 1'b0;
      m_rdata = rv;
      n_checks++; if ({bus.rd_dn, bus.grant, bus.rdata} !== {4'b0100, 4'b0100, rv}) begin n_errors++; $display("FAIL lock_rd_done: got %b/%b/%h want 0100/0100/%h", bus.rd_dn, bus.grant, bus.rdata, rv); end
      step();
      n_checks++; if ({bus.mem_wr, bus.mem_wdata, bus.mem_addr, bus.grant} !== {1'b1, wv, 32'h20, 4'b0100}) begin n_errors++; $display("FAIL lock_wr_issue: got %b/%h/%h/%b want 1/%h/00000020/0100", bus.mem_wr, bus.mem_wdata, bus.mem_addr, bus.grant, wv); end
      bus.mem_ack = 1'b1; bus.wr[2] = 1'b0;
      step();
      bus.mem_ack = 1'b0;
      n_checks++; if ({bus.wr_dn, bus.grant} !== {4'b0100, 4'b0100}) begin n_errors++; $display("FAIL lock_wr_done: got %b/%b want 0100/0100", bus.wr_dn, bus.grant); end
      step(); step();
      n_checks++; if (bus.grant !== 4'b0100) begin n_errors++; $display("FAIL lock_hold: got %b want 0100", bus.grant); end
      bus.lock[2] = 1'b0; bus.req[2] = 1'b0;
      step();
      m_last = 2;
      n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL lock_release: got %b want 0000", bus.grant); end
      exp_oh = 4'b0001 << model_pick(bus.req, m_last);
      step();
      n_checks++; if (bus.grant !== exp_oh) begin n_errors++; $display("FAIL lock_next_grant: got %b want %b", bus.grant, exp_oh); end
      bus.req = 4'b0000;
      step();
      m_last = 0;
   endtask

   task automatic test_timeout(input bit ack_at_limit);
      int          i, hi, bad;
      logic        is_wr;
      logic [3:0]  oh;
      logic [31:0] rv;
      i = $urandom_range(0, 3); is_wr = 1'($urandom_range(0, 1)); rv = $urandom;
      oh = 4'b0001 << i;
      bus.req = oh; bus.rd = is_wr ? 4'b0 : oh; bus.wr = is_wr ? oh : 4'b0;
      bus.addr_in[32*i +: 32] = $urandom;
      step(); step();
      bus.req = 4'b0000; bus.rd = 4'b0000; bus.wr = 4'b0000;
      hi = 0; bad = 0;
      for (int c = 1; c <= 255; c++) begin
         if ((is_wr ? bus.mem_wr : bus.mem_rd) === 1'b1) hi++;
         if ({bus.rd_dn, bus.wr_dn, bus.err} !== 12'd0 || bus.grant !== oh) bad++;
         if (c == 255 && ack_at_limit) begin bus.mem_ack = 1'b1; bus.mem_rdata = rv; end
         step();
      end
      bus.mem_ack = 1'b0;
      m_last = i;
      if (ack_at_limit && !is_wr) m_rdata = rv;
      n_checks++; if (hi !== 255) begin n_errors++; $display("FAIL tmo_strobe_len(ack=%0d): got %0d want 255", ack_at_limit, hi); end
      n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL tmo_early_event(ack=%0d): got %0d bad cycles want 0", ack_at_limit, bad); end
      n_checks++; if ({bus.mem_rd, bus.mem_wr, bus.grant} !== 6'd0) begin n_errors++; $display("FAIL tmo_release(ack=%0d): got %b want 000000", ack_at_limit, {bus.mem_rd, bus.mem_wr, bus.grant}); end
      if (ack_at_limit) begin
         n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err} !== {is_wr ? 4'b0 : oh, is_wr ? oh : 4'b0, 4'b0}) begin n_errors++; $display("FAIL tmo_ack_wins: got rd_dn=%b wr_dn=%b err=%b", bus.rd_dn, bus.wr_dn, bus.err); end
      end else begin
         n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err} !== {8'd0, oh}) begin n_errors++; $display("FAIL tmo_err: got rd_dn=%b wr_dn=%b err=%b want err=%b", bus.rd_dn, bus.wr_dn, bus.err, oh); end
      end
      n_checks++; if (bus.rdata !== m_rdata) begin n_errors++; $display("FAIL tmo_rdata: got %h want %h", bus.rdata, m_rdata); end
      step();
      n_checks++; if (bus.err !== 4'd0) begin n_errors++; $display("FAIL tmo_err_width: got %b want 0000", bus.err); end
   endtask

   task automatic test_both_strobes();
      int         i;
      logic [3:0] oh;
      i = $urandom_range(0, 3); oh = 4'b0001 << i;
      bus.req = oh; bus.rd = oh; bus.wr = oh;
      step(); step();
      m_last = i;
      n_checks++; if ({bus.err, bus.mem_rd, bus.mem_wr, bus.grant} !== {oh, 6'd0}) begin n_errors++; $display("FAIL both_strobe_err: got err=%b strobes=%b grant=%b want %b/00/0000", bus.err, {bus.mem_rd, bus.mem_wr}, bus.grant, oh); end
      clear_inputs();
      step();
      n_checks++; if (bus.err !== 4'd0) begin n_errors++; $display("FAIL both_strobe_width: got %b want 0000", bus.err); end
   endtask

   task automatic test_reset_mid_wait();
      int         i;
      logic [3:0] oh;
      i = $urandom_range(0, 3); oh = 4'b0001 << i;
      bus.req = oh; bus.rd = oh; bus.addr_in[32*i +: 32] = $urandom;
      step(); step(); step();
      rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      step();
      m_last = 3; m_rdata = 32'd0;
      n_checks++; if ({bus.grant, bus.bus_busy, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.rdata} !== 75'd0) begin n_errors++; $display("FAIL rst_wait_outputs: not all zero (grant=%b rd=%b addr=%h)", bus.grant, bus.mem_rd, bus.mem_addr); end
      n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err} !== 12'd0) begin n_errors++; $display("FAIL rst_wait_pulses: got %h want 000", {bus.rd_dn, bus.wr_dn, bus.err}); end
      rst = 1'b0;
      clear_inputs();
      step();
      n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err} !== 12'd0) begin n_errors++; $display("FAIL rst_wait_late_pulse: got %h want 000", {bus.rd_dn, bus.wr_dn, bus.err}); end
      bus.req = 4'b1111;
      step();
      n_checks++; if (bus.grant !== (4'b0001 << model_pick(4'b1111, m_last))) begin n_errors++; $display("FAIL rst_wait_regrant: got %b want 0001", bus.grant); end
      bus.req = 4'b0000;
      step();
      m_last = 0;
   endtask

   task automatic test_random(input int n);
      logic [3:0]  mask, op_wr, oh;
      logic [31:0] a [4];
      logic [31:0] d [4];
      logic [31:0] rv;
      logic [1:0]  es;
      logic        cur_wr, locked;
      int          exp, burst, dly;
      for (int t = 0; t < n; t++) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            op_wr[i] = 1'($urandom_range(0, 1)); a[i] = $urandom; d[i] = $urandom;
            bus.addr_in[32*i +: 32] = a[i]; bus.wdata_in[32*i +: 32] = d[i];
         end
         bus.rd = ~op_wr; bus.wr = op_wr; bus.req = mask; bus.lock = 4'b0;
         exp = model_pick(mask, m_last); oh = 4'b0001 << exp;
         burst = $urandom_range(1, 3);
         step();
         n_checks++; if ({bus.grant, bus.owner, bus.bus_busy} !== {oh, 2'(exp), 1'b1}) begin n_errors++; $display("FAIL rnd_grant[%0d]: got %b/%0d/%b want %b/%0d/1", t, bus.grant, bus.owner, bus.bus_busy, oh, exp); end
         for (int b = 0; b < burst; b++) begin
            step();
            cur_wr = op_wr[exp]; es = cur_wr ? 2'b01 : 2'b10;
            n_checks++; if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {es, a[exp]}) begin n_errors++; $display("FAIL rnd_issue[%0d.%0d]: got %b/%h want %b/%h", t, b, {bus.mem_rd, bus.mem_wr}, bus.mem_addr, es, a[exp]); end
            if (cur_wr) begin
               n_checks++; if (bus.mem_wdata !== d[exp]) begin n_errors++; $display("FAIL rnd_wdata[%0d.%0d]: got %h want %h", t, b, bus.mem_wdata, d[exp]); end
            end
            dly = $urandom_range(1, 5);
            for (int w = 1; w < dly; w++) begin
               step();
               n_checks++; if ({bus.mem_rd, bus.mem_wr, bus.grant} !== {es, oh}) begin n_errors++; $display("FAIL rnd_hold[%0d.%0d]: got %b/%b want %b/%b", t, b, {bus.mem_rd, bus.mem_wr}, bus.grant, es, oh); end
            end
            locked = (b < burst - 1);
            rv = $urandom;
            bus.mem_ack = 1'b1; bus.mem_rdata = rv; bus.lock[exp] = locked;
            if ($urandom_range(0, 1) == 1) bus.req[exp] = 1'b0;
            op_wr[exp] = 1'($urandom_range(0, 1)); a[exp] = $urandom; d[exp] = $urandom;
            bus.rd[exp] = ~op_wr[exp]; bus.wr[exp] = op_wr[exp];
            bus.addr_in[32*exp +: 32] = a[exp]; bus.wdata_in[32*exp +: 32] = d[exp];
            step();
            bus.mem_ack = 1'b0;
            if (!cur_wr) m_rdata = rv;
            if (!locked) m_last = exp;
            n_checks++; if ({bus.rd_dn, bus.wr_dn, bus.err} !== {cur_wr ? 4'b0 : oh, cur_wr ? oh : 4'b0, 4'b0}) begin n_errors++; $display("FAIL rnd_done[%0d.%0d]: got rd_dn=%b wr_dn=%b err=%b", t, b, bus.rd_dn, bus.wr_dn, bus.err); end
            n_checks++; if ({bus.rdata, bus.mem_rd, bus.mem_wr, bus.grant} !== {m_rdata, 2'b00, locked ? oh : 4'b0}) begin n_errors++; $display("FAIL rnd_after[%0d.%0d]: got rdata=%h grant=%b want %h/%b", t, b, bus.rdata, bus.grant, m_rdata, locked ? oh : 4'b0); end
         end
         bus.lock = 4'b0;
      end
      clear_inputs();
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_rotation();
      test_read();
      test_lock();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_both_strobes();
      test_reset_mid_wait();
      test_random(40);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter TMO, default 255, meaning the ack timeout in cycles (8-bit counter).
REQ-003 SHALL have clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have req  in  4  per-requester bus request (level).
REQ-006 SHALL have lock  in  4  per-requester hold-bus request (halt), sampled at transfer completion.
REQ-007 SHALL have rd  in  4 and wr  in  4  per-requester read/write strobe (level, valid while granted).
REQ-008 SHALL have addr_in  in  128 and wdata_in  in  128  per-requester address/write data, requester i at bits [32i+31:32i].
REQ-009 SHALL have grant  out  4  one-hot owner, plus owner  out  2  encoded owner index.
REQ-010 SHALL have bus_busy  out  1  high while any grant is active.
REQ-011 SHALL have mem_addr  out  32, mem_wdata  out  32, mem_rd  out  1, mem_wr  out  1  memory request.
REQ-012 SHALL have mem_rdata  in  32 and mem_ack  in  1  memory completion.
REQ-013 SHALL have rdata  out  32, rd_dn  out  4, wr_dn  out  4, err  out  4  per-requester completion/error pulses.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-015 In IDLE with req!=0, the next edge SHALL grant the first requester with req=1, searching cyclically from (last_owner+1) mod 4, set bus_busy=1, and enter ISSUE.
REQ-016 Grant SHALL be registered: one cycle from req to grant; the grant SHALL NOT change while in ISSUE or WAIT.
REQ-017 In ISSUE with exactly one of rd/wr set for the owner, the next edge SHALL latch mem_addr (and mem_wdata for a write), assert mem_rd or mem_wr, and enter WAIT.
REQ-018 In ISSUE with both rd and wr set, the block SHALL pulse err[owner] for 1 cycle, issue nothing, and release to IDLE.
REQ-019 In ISSUE with neither strobe set, the block SHALL release to IDLE if req[owner]=0 (and lock[owner]=0); otherwise it SHALL remain in ISSUE.
REQ-020 In WAIT, mem_rd/mem_wr SHALL be held until the first cycle with mem_ack=1.
REQ-021 On mem_ack, the next edge SHALL drop mem_rd/mem_wr, load rdata=mem_rdata (reads only), and pulse rd_dn[owner] or wr_dn[owner] for exactly 1 cycle.
REQ-022 After mem_ack with lock[owner]=1, the block SHALL return to ISSUE keeping the grant (back-to-back locked transfers, no arbitration).
REQ-023 After mem_ack with lock[owner]=0, the block SHALL clear grant and bus_busy, set last_owner=owner, and enter IDLE.
REQ-024 The timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-025 When the timeout counter reaches TMO, the block SHALL drop mem_rd/mem_wr, pulse err[owner], and release to IDLE regardless of lock.
REQ-026 When mem_ack arrives in the same cycle as the timeout, the ack SHALL win and no err SHALL be produced.
REQ-027 mem_ack outside WAIT SHALL be ignored, with no pulses and no state change.
REQ-028 rdata SHALL hold its value until the next completed read.
REQ-029 A requester dropping req while in WAIT SHALL NOT abort the transfer.

Reset
REQ-030 On rst=1 at an edge, the block SHALL enter IDLE with grant=0, owner=0, bus_busy=0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, rdata=0, rd_dn=wr_dn=err=0, timeout counter=0, and last_owner=3, so requester 0 wins first.
REQ-031 Reset SHALL take priority over all other inputs, including mid-WAIT; an in-flight transfer SHALL be abandoned with no dn or err pulse.

Verification
REQ-032 req=4'b0101 from reset -> grant=0001 after 1 cycle; on release with req unchanged -> next grant=0100.
REQ-033 Owner 1 rd=1, addr=0x100, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_rd high 3 cycles, rd_dn=0010 for 1 cycle, rdata=0xDEADBEEF.
REQ-034 Owner 2 lock=1 doing read then write to 0x20 while req[0]=1 -> grant stays 0100 across both transfers; req 0 is granted only after lock drops.
REQ-035 No mem_ack for 255 WAIT cycles -> err[owner] pulse, mem_rd=0, IDLE; with mem_ack on cycle 255 instead -> dn pulse, no err.
REQ-036 rst asserted during WAIT -> all outputs zero next cycle, no dn/err pulse; subsequent req=1111 -> grant=0001.
